// File: rtl/register_file_mp_if.sv
// rtl/register_file_mp_if.sv - write, read, scoreboard and clear signals of the register file
interface register_file_mp_if #(
  parameter int N        = 32,
  parameter int ADDR     = 5,
  parameter int RD_PORTS = 2
);
  logic                     Reg_Write_i;
  logic [ADDR-1:0]          Write_Register_i;
  logic [N-1:0]             Write_Data_i;
  logic [N/8-1:0]           Byte_En_i;
  logic [RD_PORTS*ADDR-1:0] Read_Register_i;
  logic [RD_PORTS*N-1:0]    Read_Data_o;
  logic                     Reserve_i;
  logic [ADDR-1:0]          Reserve_Register_i;
  logic [RD_PORTS-1:0]      Busy_o;
  logic                     Clear_i;
  logic                     Clear_Busy_o;

  modport master (
    output Reg_Write_i, Write_Register_i, Write_Data_i, Byte_En_i, Read_Register_i,
    output Reserve_i, Reserve_Register_i, Clear_i,
    input  Read_Data_o, Busy_o, Clear_Busy_o
  );

  modport slave (
    input  Reg_Write_i, Write_Register_i, Write_Data_i, Byte_En_i, Read_Register_i,
    input  Reserve_i, Reserve_Register_i, Clear_i,
    output Read_Data_o, Busy_o, Clear_Busy_o
  );
endinterface

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-read-port register file with byte writes, bypass, scoreboard and clear engine
module register_file_mp #(
  parameter int N        = 32,
  parameter int ADDR     = 5,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              reset,
  register_file_mp_if.slave bus
);
  localparam int NB    = N / 8;
  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic [N-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;

  logic            wr_ok;
  logic            rs_ok;
  logic [N-1:0]    wr_merged;
  logic [RD_PORTS*N-1:0] rd_data;
  logic [RD_PORTS-1:0]   rd_busy;

  // Writes and reserves are only honoured in IDLE, outside reset, and never to a hard-wired r0.
  assign wr_ok = reset && (state_q == S_IDLE) && bus.Reg_Write_i &&
                 !((ZERO_REG != 0) && (bus.Write_Register_i == '0));
  assign rs_ok = (state_q == S_IDLE) && bus.Reserve_i &&
                 !((ZERO_REG != 0) && (bus.Reserve_Register_i == '0));

  // Byte-lane merge of the incoming word over the stored word; shared by the write path and the bypass.
  always_comb begin
    wr_merged = mem_q[bus.Write_Register_i];
    for (int k = 0; k < NB; k++) begin
      if (bus.Byte_En_i[k]) wr_merged[8*k +: 8] = bus.Write_Data_i[8*k +: 8];
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR-1:0] ra;
    logic            is_zero;
    logic            hit;
    assign ra      = bus.Read_Register_i[p*ADDR +: ADDR];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit     = (BYPASS != 0) && wr_ok && (ra == bus.Write_Register_i);
    assign rd_data[p*N +: N] = is_zero ? '0 : (hit ? wr_merged : mem_q[ra]);
    assign rd_busy[p]        = !is_zero && busy_q[ra];
  end

  assign bus.Read_Data_o  = rd_data;
  assign bus.Busy_o       = rd_busy;
  assign bus.Clear_Busy_o = (state_q == S_CLEAR);

  // Clear FSM state and sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start a sweep on Clear_i, walk every address once, then return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Clear_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + ADDR'(1);
        if (cnt_q == ADDR'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage and scoreboard: sweep-clear in CLEAR, otherwise write then reserve so reserve wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q]  <= '0;
      busy_q[cnt_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[bus.Write_Register_i]  <= wr_merged;
        busy_q[bus.Write_Register_i] <= 1'b0;
      end
      if (rs_ok) busy_q[bus.Reserve_Register_i] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized and directed check of register_file_mp against a reference model
module tb_register_file_mp;
  localparam int N     = 32;
  localparam int ADDR  = 5;
  localparam int RP    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [4:0]  ra0, ra1;
  logic        rs;
  logic [4:0]  rsa;
  logic        clr;

  register_file_mp_if #(.N(N), .ADDR(ADDR), .RD_PORTS(RP)) bus_a ();
  register_file_mp_if #(.N(N), .ADDR(ADDR), .RD_PORTS(RP)) bus_b ();

  register_file_mp #(.N(N), .ADDR(ADDR), .RD_PORTS(RP), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
  register_file_mp #(.N(N), .ADDR(ADDR), .RD_PORTS(RP), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

  assign bus_a.Reg_Write_i        = we;
  assign bus_a.Write_Register_i   = wa;
  assign bus_a.Write_Data_i       = wd;
  assign bus_a.Byte_En_i          = be;
  assign bus_a.Read_Register_i    = {ra1, ra0};
  assign bus_a.Reserve_i          = rs;
  assign bus_a.Reserve_Register_i = rsa;
  assign bus_a.Clear_i            = clr;
  assign bus_b.Reg_Write_i        = we;
  assign bus_b.Write_Register_i   = wa;
  assign bus_b.Write_Data_i       = wd;
  assign bus_b.Byte_En_i          = be;
  assign bus_b.Read_Register_i    = {ra1, ra0};
  assign bus_b.Reserve_i          = rs;
  assign bus_b.Reserve_Register_i = rsa;
  assign bus_b.Clear_i            = clr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: config 0 = bypass + zero reg, config 1 = neither.
  logic [31:0] m_reg  [2][DEPTH];
  bit          m_busy [2][DEPTH];
  bit          m_clr;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] en);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = en[k] ? nw[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    bit zr;
    bit byp;
    zr  = (c == 0);
    byp = (c == 0);
    if (zr && a == 0) return 32'h0;
    if (byp && rst_n && !m_clr && we && a == wa) return merge(m_reg[c][a], wd, be);
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [4:0] a);
    if (c == 0 && a == 0) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic [31:0] obs_rd(input int c, input int p);
    logic [63:0] v;
    v = (c == 0) ? bus_a.Read_Data_o : bus_b.Read_Data_o;
    return v[p*32 +: 32];
  endfunction

  function automatic logic [1:0] obs_busy(input int c);
    return (c == 0) ? bus_a.Busy_o : bus_b.Busy_o;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
    m_clr = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (m_clr) begin
        m_reg[c][m_cnt]  = '0;
        m_busy[c][m_cnt] = 1'b0;
      end else begin
        if (we && !(c == 0 && wa == 0)) begin
          m_reg[c][wa]  = merge(m_reg[c][wa], wd, be);
          m_busy[c][wa] = 1'b0;
        end
        if (rs && !(c == 0 && rsa == 0)) m_busy[c][rsa] = 1'b1;
      end
    end
    if (m_clr) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_clr = 1'b0;
        m_cnt = 0;
      end
    end else if (clr) begin
      m_clr = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < 2; c++) begin
      check_eq($sformatf("rd%0d_p0", c), obs_rd(c, 0), exp_rd(c, ra0));
      check_eq($sformatf("rd%0d_p1", c), obs_rd(c, 1), exp_rd(c, ra1));
      check_eq($sformatf("busy%0d", c), {30'd0, obs_busy(c)}, {30'd0, exp_busy(c, ra1), exp_busy(c, ra0)});
    end
    check_eq("clr_busy_a", {31'd0, bus_a.Clear_Busy_o}, {31'd0, m_clr});
    check_eq("clr_busy_b", {31'd0, bus_b.Clear_Busy_o}, {31'd0, m_clr});
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; be = 0; rs = 0; rsa = 0; clr = 0; ra0 = 0; ra1 = 0;
  endtask

  task automatic randomize_inputs();
    we  = $urandom_range(0, 1);
    wa  = 5'($urandom);
    wd  = $urandom;
    be  = 4'($urandom);
    rs  = ($urandom_range(0, 3) == 0);
    rsa = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
    ra0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
    ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 3));
    clr = 1'b0;
  endtask

  task automatic run_clear(input string tag, input bit poke_r9);
    int len;
    clr = 1'b1;
    step();
    clr = 1'b0;
    len = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_a.Clear_Busy_o) break;
      len++;
      if (poke_r9 && i == 5) begin
        we = 1; wa = 9; wd = 32'hCAFEF00D; be = 4'hF;
      end else begin
        we = 0;
      end
      step();
    end
    check_eq({tag, "_len"}, len, 32);
  endtask

  initial begin
    idle();
    model_reset();

    // Reset with toggling inputs: everything reads zero.
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      clr = 1'($urandom);
      step();
    end
    idle();
    rst_n = 1'b1;
    #1;
    check_eq("rst_rd_a", obs_rd(0, 0), 32'h0);

    // Full write to r5, read on both ports.
    we = 1; wa = 5; wd = 32'hDEADBEEF; be = 4'hF;
    step();
    idle(); ra0 = 5; ra1 = 5; #1;
    check_eq("r5_a_p0", obs_rd(0, 0), 32'hDEADBEEF);
    check_eq("r5_a_p1", obs_rd(0, 1), 32'hDEADBEEF);
    check_eq("r5_b_p1", obs_rd(1, 1), 32'hDEADBEEF);
    step();

    // Byte-enabled write with same-cycle read.
    we = 1; wa = 7; wd = 32'h11223344; be = 4'hF;
    step();
    we = 1; wa = 7; wd = 32'hAABBCCDD; be = 4'b0101; ra0 = 7; ra1 = 7; #1;
    check_eq("byp_a", obs_rd(0, 0), 32'h11BB33DD);
    check_eq("nobyp_b", obs_rd(1, 0), 32'h11223344);
    step();
    idle(); ra0 = 7; #1;
    check_eq("r7_a", obs_rd(0, 0), 32'h11BB33DD);
    check_eq("r7_b", obs_rd(1, 0), 32'h11BB33DD);
    step();

    // Zero register: write and reserve r0.
    we = 1; wa = 0; wd = 32'hFFFFFFFF; be = 4'hF; rs = 1; rsa = 0;
    step();
    idle(); #1;
    check_eq("r0_a", obs_rd(0, 0), 32'h0);
    check_eq("r0_busy_a", {30'd0, obs_busy(0)}, 32'h0);
    check_eq("r0_b", obs_rd(1, 0), 32'hFFFFFFFF);
    step();

    // Scoreboard on r3.
    rs = 1; rsa = 3;
    step();
    idle(); ra0 = 3; ra1 = 3; #1;
    check_eq("r3_rsv", {30'd0, obs_busy(0)}, 32'h3);
    we = 1; wa = 3; wd = 32'h12345678; be = 4'hF;
    step();
    idle(); ra0 = 3; ra1 = 3; #1;
    check_eq("r3_wr", {30'd0, obs_busy(0)}, 32'h0);
    we = 1; wa = 3; wd = 32'h1; be = 4'h1; rs = 1; rsa = 3;
    step();
    idle(); ra0 = 3; ra1 = 3; #1;
    check_eq("r3_both", {30'd0, obs_busy(0)}, 32'h3);
    step();

    // Fill, clear with a dropped mid-clear write to r9, then write after the clear.
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wa = 5'(i); wd = $urandom | 32'h1; be = 4'hF; rs = 1; rsa = 5'(i);
      step();
    end
    idle();
    run_clear("clr1", 1'b1);
    we = 1; wa = 10; wd = 32'h5A5A5A5A; be = 4'hF;
    step();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      ra0 = 5'(i); ra1 = 5'(DEPTH - 1 - i);
      step();
    end
    ra0 = 9; ra1 = 10; #1;
    check_eq("r9_dropped", obs_rd(0, 0), 32'h0);
    check_eq("r10_after", obs_rd(0, 1), 32'h5A5A5A5A);
    step();

    // Random traffic with occasional clears.
    for (int i = 0; i < 800; i++) begin
      randomize_inputs();
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 40; i++) step();

    // Reset ten cycles into a clear.
    for (int i = 0; i < 8; i++) begin
      we = 1; wa = 5'(i + 1); wd = $urandom | 32'h1; be = 4'hF;
      step();
    end
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_clr_a", {31'd0, bus_a.Clear_Busy_o}, 32'h0);
    check_eq("rst_clr_b", {31'd0, bus_b.Clear_Busy_o}, 32'h0);
    model_reset();
    for (int i = 0; i < DEPTH / 2; i++) begin
      ra0 = 5'(i); ra1 = 5'(DEPTH - 1 - i);
      step();
    end
    idle();
    rst_n = 1'b1;
    run_clear("clr2", 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the processor datapath, the next generation of the single-write, two-read register file. It adds a configurable number of read ports, byte-enabled writes, same-cycle write-to-read bypass, an optional hard-wired zero register, a per-register busy scoreboard, and a sequential clear engine. It sits between the decode stage, which reserves destinations and reads operands, and the write-back stage, which writes results.

## Interface
- N, 32, word width in bits; must be a multiple of 8.
- ADDR, 5, address width; depth is 2**ADDR.
- RD_PORTS, 2, number of read ports (1..8).
- BYPASS, 1, 1 enables the write-to-read bypass; 0 gives pure register read.
- ZERO_REG, 1, 1 hard-wires register 0 to zero and never marks it busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Reg_Write_i  in  1  write strobe.
- Write_Register_i  in  ADDR  write address.
- Write_Data_i  in  N  write data.
- Byte_En_i  in  N/8  byte lanes to write; bit k covers bits [8k+7:8k].
- Read_Register_i  in  RD_PORTS*ADDR  packed read addresses; port p uses [p*ADDR +: ADDR].
- Read_Data_o  out  RD_PORTS*N  packed read data; port p uses [p*N +: N].
- Reserve_i  in  1  marks a destination register busy.
- Reserve_Register_i  in  ADDR  register to reserve.
- Busy_o  out  RD_PORTS  scoreboard bit of each read port's address.
- Clear_i  in  1  starts a sequential clear of all registers and busy bits.
- Clear_Busy_o  out  1  high while the clear engine runs.

## Operation
- Reset (reset=0): all registers = 0, all busy bits = 0, FSM = IDLE, clear counter = 0. Read_Data_o = 0, Busy_o = 0, Clear_Busy_o = 0.
- Write: if Reg_Write_i=1 in IDLE, register[Write_Register_i] is updated only on the lanes selected by Byte_En_i. Unselected lanes are unchanged. Byte_En_i=0 writes nothing but still clears the busy bit.
- ZERO_REG=1: writes and reserves to address 0 are discarded; reads of address 0 return 0; Busy_o for address 0 is 0.
- Read: combinational, and each port is independent. Several ports may read the same address.
- Bypass (BYPASS=1, IDLE, Reg_Write_i=1, read address = write address, and the address is not the zero register): Read_Data_o returns the byte-merged word. Selected lanes come from Write_Data_i; the other lanes come from the stored value.
- Scoreboard:
  - Reserve_i sets busy[Reserve_Register_i].
  - A write clears busy[Write_Register_i].
  - If reserve and write hit the same register in the same cycle, reserve wins and the bit stays 1.
  - Busy_o reflects the registered bit and is not bypassed.
- Clear FSM:
  - States: IDLE and CLEAR.
  - IDLE -> CLEAR when Clear_i=1; the counter loads 0.
  - In CLEAR, each cycle zeroes register[counter] and busy[counter], then increments the counter.
  - CLEAR -> IDLE on the edge that clears address 2**ADDR-1; the counter wraps to 0.
  - Clear_i asserted while in CLEAR is ignored; there is no restart.
  - In CLEAR, Reg_Write_i and Reserve_i are ignored and bypass is disabled. Reads stay live and return the partially cleared contents.
  - Reset during CLEAR aborts it: FSM = IDLE and everything is zeroed.

## Timing
- Read latency is 0 cycles (combinational from address to data).
- A write is visible at the stored value after the next rising edge. With BYPASS=1 it is visible on the read port in the same cycle.
- Reserve or write affects Busy_o the cycle after the edge.
- Clear_Busy_o rises the cycle after Clear_i is sampled and stays high for exactly 2**ADDR cycles.
- The first write accepted after a clear is the one sampled in the cycle Clear_Busy_o is low again.
- Reset is asynchronous assert and synchronous deassert by the system. Outputs go to their reset values immediately.

## Test plan
- Reset and basic write/read:
  - Assert reset with all inputs toggling: every Read_Data_o = 0, Busy_o = 0, Clear_Busy_o = 0.
  - Write 0xDEADBEEF to r5 with Byte_En=4'hF, then read r5 on all ports: each port returns 0xDEADBEEF.
- Byte enables and bypass:
  - With r7 = 0x11223344, write 0xAABBCCDD, Byte_En=4'b0101, while reading r7 in the same cycle.
  - BYPASS=1: the port returns 0x11BB33DD that cycle; the stored value is 0x11BB33DD after the edge.
  - BYPASS=0: the port returns 0x11223344 that cycle.
- Zero register:
  - Write 0xFFFFFFFF to r0 and reserve r0: r0 reads 0 and Busy_o = 0 (ZERO_REG=1).
  - With ZERO_REG=0: r0 reads 0xFFFFFFFF.
- Scoreboard:
  - Reserve r3: Busy_o = 1 the next cycle for any port addressing r3.
  - Write r3: Busy_o = 0 the next cycle.
  - Reserve and write r3 in the same cycle: Busy_o stays 1.
- Clear sequence:
  - Fill all 32 registers with nonzero data, then pulse Clear_i.
  - Clear_Busy_o is high for exactly 32 cycles. A write to r9 attempted mid-clear is dropped.
  - Afterwards all registers read 0, all busy bits are 0, and a write after Clear_Busy_o falls succeeds.
- Reset mid-clear:
  - Assert reset 10 cycles into CLEAR: Clear_Busy_o = 0 immediately and all registers read 0.
  - After release, Clear_i starts a fresh 32-cycle clear.
